vmem_rect_fill: RTL and testbench
=================================

Name: vmem_rect_fill

Overview:
- MMIO-programmed rectangle-fill engine placed directly upstream of the video memory.
- Owns the vmem write port: merges CPU direct pixel writes with hardware-generated fill writes.
- Emits one pixel write per cycle so firmware can clear or paint regions without per-pixel stores.
- Results are consumed unchanged by the display scan-out path, which reads vmem at {y[7:0], x[7:0]}.

Parameters:
- SCREEN_W, 240, visible pixels per row; x range is 0..SCREEN_W-1.
- SCREEN_H, 240, visible rows; y range is 0..SCREEN_H-1.
- COLOR_W, 3, pixel width in bits (R,G,B one bit each).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- reg_we_i  in  1  register write strobe, already qualified by the top-level address decode.
- reg_addr_i  in  5  byte address within the register window; bits [4:2] select the register.
- reg_wdata_i  in  32  register write data.
- reg_rdata_o  out  32  registered read data, valid 1 cycle after the address is presented.
- cpu_vmem_we_i  in  1  CPU direct pixel write.
- cpu_vmem_addr_i  in  16  CPU pixel address, {y, x}.
- cpu_vmem_wdata_i  in  COLOR_W  CPU pixel colour.
- vmem_we_o  out  1  merged write enable to vmem.
- vmem_addr_o  out  16  merged address, {y[7:0], x[7:0]}.
- vmem_wdata_o  out  COLOR_W  merged colour.
- busy_o  out  1  high from the accepted start until the DONE state.
- done_o  out  1  1-cycle pulse when a fill completes.

Behaviour:
- Register map (word index = reg_addr_i[4:2]):
  - 0 CTRL: a write with bit0=1 requests start. Reads return {30'b0, done_sticky, busy}. done_sticky is set by DONE and cleared by a CTRL write.
  - 1 X0, 2 Y0: 8 bits, [7:0].
  - 3 W, 4 H: 9 bits, [8:0].
  - 5 COLOR: [COLOR_W-1:0].
  - 6 PIXCNT (read-only): count of pixels written by the last/current fill, 17 bits.
  - 7: reads as 0.
- Reset values: all registers, the FSM (IDLE), the counters, every output = 0. reg_rdata_o = 0.
- Read path: reg_rdata_o updates every cycle from the reg_addr_i of the previous cycle, with 1-cycle latency.
- FSM states and transitions:
  - IDLE: on a start request go to SETUP. Latch X0/Y0/W/H/COLOR into working copies. Clear PIXCNT.
  - SETUP (1 cycle): clip the extents to the screen.
    - xe = min(X0+W, SCREEN_W), ye = min(Y0+H, SCREEN_H), computed at 10-bit width.
    - If W==0, H==0, X0>=SCREEN_W or Y0>=SCREEN_H, go to DONE with no writes.
    - Otherwise set cx=X0, cy=Y0 and go to FILL.
  - FILL: each cycle with no CPU write, issue a write at {cy,cx} with the colour, then PIXCNT++.
    - Advance: if cx==xe-1, then cx=X0 and cy++; otherwise cx++.
    - The write at cx==xe-1, cy==ye-1 is the last; after it go to DONE.
  - DONE (1 cycle): pulse done_o, set done_sticky, return to IDLE.
- busy_o = (state != IDLE). A start request while busy is ignored.
- Geometry and colour writes while busy update the programmed registers only. The running fill uses its latched copies.
- Arbitration:
  - A CPU direct write always wins and passes through combinationally to vmem_*_o.
  - In that cycle the fill does not advance: no write, counters hold.
  - Only one write reaches vmem per cycle.
- Latency:
  - Start write at cycle t: SETUP at t+1, first fill write at t+2.
  - An unstalled W×H fill writes in cycles t+2 .. t+1+W·H, and done_o fires at t+2+W·H.
- rst_i asserted mid-fill: FSM returns to IDLE in the next cycle and no further fill writes are issued. Pixels already written remain. done_o is not pulsed.

Decomposition:
- Shared include (with config.vh): register word indices, CTRL bit positions, SCREEN_W/H defaults, and state encodings (IDLE=0, SETUP=1, FILL=2, DONE=3).
- One natural sub-module, vmem_wr_arb: a combinational CPU-priority write merger that outputs a fill_stall signal.
- The FSM and counters stay in vmem_rect_fill.

Test Plan:
- Programming: X0=10, Y0=20, W=3, H=2, COLOR=5, then CTRL=1.
  - Required: exactly 6 writes, in order to 0x140A, 0x140B, 0x140C, 0x150A, 0x150B, 0x150C, with data 5.
  - done_o fires 8 cycles after the start write. PIXCNT reads 6.
- Clipping: X0=238, Y0=239, W=10, H=10.
  - Required: writes only to 0xEFEE and 0xEFEF, then DONE. PIXCNT reads 2.
- Zero size: W=0, H=5, start.
  - Required: no vmem writes, done_o 2 cycles after the start write, CTRL read returns 0x2.
- CPU contention: a 4×1 fill at 0,0 with CPU writes (addr 0x0505, data 7) injected in the 2nd and 3rd fill cycles.
  - Required: CPU writes appear unmodified and all 4 fill pixels are still written exactly once.
  - done_o is delayed by 2 cycles.
- Start while busy, plus reprogramming: during a 240×240 fill, write COLOR=2 and CTRL=1.
  - Required: the fill keeps its original colour and no restart happens. PIXCNT ends at 57600.
  - A second start issued after DONE uses colour 2.
- Mid-fill reset: assert rst_i for 1 cycle after 100 pixels of a 50×50 fill.
  - Required: no further writes, busy_o=0, done_o never pulses, all registers read 0.

Source files
------------

// File: rtl/vmem_rect_fill_pkg.sv
// Shared definitions for the rectangle-fill engine: register map, CTRL bits,
// screen defaults, FSM encoding and the extent-clipping helper.
package vmem_rect_fill_pkg;

    localparam int SCREEN_W_DEF = 240;
    localparam int SCREEN_H_DEF = 240;
    localparam int COLOR_W_DEF  = 3;

    // Register word indices (reg_addr[4:2])
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_X0     = 3'd1;
    localparam logic [2:0] REG_Y0     = 3'd2;
    localparam logic [2:0] REG_W      = 3'd3;
    localparam logic [2:0] REG_H      = 3'd4;
    localparam logic [2:0] REG_COLOR  = 3'd5;
    localparam logic [2:0] REG_PIXCNT = 3'd6;

    // CTRL bit positions: start on write, busy/done_sticky on read
    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_BUSY_BIT  = 0;
    localparam int CTRL_DONE_BIT  = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } fill_state_e;

    // Exclusive end coordinate of a span, clipped to the screen limit.
    function automatic logic [9:0] clip_end(input logic [7:0] org,
                                            input logic [8:0] size,
                                            input logic [9:0] limit);
        logic [9:0] e;
        e = {2'b00, org} + {1'b0, size};
        return (e > limit) ? limit : e;
    endfunction

endpackage

// File: rtl/vmem_rect_fill_if.sv
// Register bus, CPU direct pixel port, merged vmem write port and status
// of the rectangle-fill engine. The engine uses the slave side.
interface vmem_rect_fill_if #(
    parameter int COLOR_W = 3
);
    logic               reg_we_i;
    logic [4:0]         reg_addr_i;
    logic [31:0]        reg_wdata_i;
    logic [31:0]        reg_rdata_o;

    logic               cpu_vmem_we_i;
    logic [15:0]        cpu_vmem_addr_i;
    logic [COLOR_W-1:0] cpu_vmem_wdata_i;

    logic               vmem_we_o;
    logic [15:0]        vmem_addr_o;
    logic [COLOR_W-1:0] vmem_wdata_o;

    logic               busy_o;
    logic               done_o;

    modport master (
        output reg_we_i, reg_addr_i, reg_wdata_i,
        output cpu_vmem_we_i, cpu_vmem_addr_i, cpu_vmem_wdata_i,
        input  reg_rdata_o, vmem_we_o, vmem_addr_o, vmem_wdata_o, busy_o, done_o
    );

    modport slave (
        input  reg_we_i, reg_addr_i, reg_wdata_i,
        input  cpu_vmem_we_i, cpu_vmem_addr_i, cpu_vmem_wdata_i,
        output reg_rdata_o, vmem_we_o, vmem_addr_o, vmem_wdata_o, busy_o, done_o
    );
endinterface

// File: rtl/vmem_rect_fill_wr_arb.sv
// CPU-priority merger for the single vmem write port. A CPU write passes
// straight through; a fill write colliding with it is told to stall.
module vmem_wr_arb #(
    parameter int COLOR_W = 3
) (
    input  logic               cpu_we_i,
    input  logic [15:0]        cpu_addr_i,
    input  logic [COLOR_W-1:0] cpu_wdata_i,
    input  logic               fill_we_i,
    input  logic [15:0]        fill_addr_i,
    input  logic [COLOR_W-1:0] fill_wdata_i,
    output logic               vmem_we_o,
    output logic [15:0]        vmem_addr_o,
    output logic [COLOR_W-1:0] vmem_wdata_o,
    output logic               fill_stall_o
);

    // Select the winning writer; idle port drives zeros.
    always_comb begin
        vmem_we_o    = 1'b0;
        vmem_addr_o  = '0;
        vmem_wdata_o = '0;
        fill_stall_o = cpu_we_i && fill_we_i;
        if (cpu_we_i) begin
            vmem_we_o    = 1'b1;
            vmem_addr_o  = cpu_addr_i;
            vmem_wdata_o = cpu_wdata_i;
        end else if (fill_we_i) begin
            vmem_we_o    = 1'b1;
            vmem_addr_o  = fill_addr_i;
            vmem_wdata_o = fill_wdata_i;
        end
    end

endmodule

// File: rtl/vmem_rect_fill.sv
// MMIO rectangle-fill engine: register file, fill FSM with clipped raster
// walk, pixel counter, and the CPU/fill write merge in front of vmem.
module vmem_rect_fill
    import vmem_rect_fill_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int COLOR_W  = COLOR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    vmem_rect_fill_if.slave   bus
);

    localparam logic [9:0] SCR_W = 10'(SCREEN_W);
    localparam logic [9:0] SCR_H = 10'(SCREEN_H);

    fill_state_e        state_q, state_d;
    logic [7:0]         x0_q, x0_d, y0_q, y0_d;
    logic [8:0]         w_q, w_d, h_q, h_d;
    logic [COLOR_W-1:0] color_q, color_d;
    // Working copies latched at start so reprogramming cannot disturb a fill
    logic [7:0]         lx0_q, lx0_d, ly0_q, ly0_d;
    logic [8:0]         lw_q, lw_d, lh_q, lh_d;
    logic [COLOR_W-1:0] lcolor_q, lcolor_d;
    logic [9:0]         xe_q, xe_d, ye_q, ye_d;
    logic [7:0]         cx_q, cx_d, cy_q, cy_d;
    logic [16:0]        pixcnt_q, pixcnt_d;
    logic               done_sticky_q, done_sticky_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [2:0]         reg_sel;
    logic               start_req;
    logic               fill_we;
    logic               fill_stall;
    logic               unused_bits;

    assign reg_sel     = bus.reg_addr_i[4:2];
    assign start_req   = bus.reg_we_i && (reg_sel == REG_CTRL) &&
                         bus.reg_wdata_i[CTRL_START_BIT];
    // Reset gates the fill immediately so no pixel lands in the reset cycle
    assign fill_we     = (state_q == ST_FILL) && !rst_i;
    assign unused_bits = ^{bus.reg_wdata_i[31:9], bus.reg_addr_i[1:0]};

    vmem_wr_arb #(.COLOR_W(COLOR_W)) u_arb (
        .cpu_we_i     (bus.cpu_vmem_we_i),
        .cpu_addr_i   (bus.cpu_vmem_addr_i),
        .cpu_wdata_i  (bus.cpu_vmem_wdata_i),
        .fill_we_i    (fill_we),
        .fill_addr_i  ({cy_q, cx_q}),
        .fill_wdata_i (lcolor_q),
        .vmem_we_o    (bus.vmem_we_o),
        .vmem_addr_o  (bus.vmem_addr_o),
        .vmem_wdata_o (bus.vmem_wdata_o),
        .fill_stall_o (fill_stall)
    );

    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.reg_rdata_o = rdata_q;

    // Next-state logic: register writes, FSM walk, counters and read mux.
    always_comb begin
        state_d       = state_q;
        x0_d          = x0_q;
        y0_d          = y0_q;
        w_d           = w_q;
        h_d           = h_q;
        color_d       = color_q;
        lx0_d         = lx0_q;
        ly0_d         = ly0_q;
        lw_d          = lw_q;
        lh_d          = lh_q;
        lcolor_d      = lcolor_q;
        xe_d          = xe_q;
        ye_d          = ye_q;
        cx_d          = cx_q;
        cy_d          = cy_q;
        pixcnt_d      = pixcnt_q;
        done_sticky_d = done_sticky_q;

        if (bus.reg_we_i) begin
            case (reg_sel)
                REG_CTRL:  done_sticky_d = 1'b0;
                REG_X0:    x0_d    = bus.reg_wdata_i[7:0];
                REG_Y0:    y0_d    = bus.reg_wdata_i[7:0];
                REG_W:     w_d     = bus.reg_wdata_i[8:0];
                REG_H:     h_d     = bus.reg_wdata_i[8:0];
                REG_COLOR: color_d = bus.reg_wdata_i[COLOR_W-1:0];
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    state_d  = ST_SETUP;
                    lx0_d    = x0_q;
                    ly0_d    = y0_q;
                    lw_d     = w_q;
                    lh_d     = h_q;
                    lcolor_d = color_q;
                    pixcnt_d = '0;
                end
            end
            ST_SETUP: begin
                xe_d = clip_end(lx0_q, lw_q, SCR_W);
                ye_d = clip_end(ly0_q, lh_q, SCR_H);
                if ((lw_q == 9'd0) || (lh_q == 9'd0) ||
                    ({2'b00, lx0_q} >= SCR_W) || ({2'b00, ly0_q} >= SCR_H)) begin
                    state_d = ST_DONE;
                end else begin
                    cx_d    = lx0_q;
                    cy_d    = ly0_q;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (!fill_stall) begin
                    pixcnt_d = pixcnt_q + 17'd1;
                    if ({2'b00, cx_q} == xe_q - 10'd1) begin
                        cx_d = lx0_q;
                        if ({2'b00, cy_q} == ye_q - 10'd1) begin
                            state_d = ST_DONE;
                        end else begin
                            cy_d = cy_q + 8'd1;
                        end
                    end else begin
                        cx_d = cx_q + 8'd1;
                    end
                end
            end
            ST_DONE: begin
                done_sticky_d = 1'b1;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);

        rdata_d = '0;
        case (reg_sel)
            REG_CTRL: begin
                rdata_d[CTRL_BUSY_BIT] = busy_q;
                rdata_d[CTRL_DONE_BIT] = done_sticky_q;
            end
            REG_X0:     rdata_d = {24'b0, x0_q};
            REG_Y0:     rdata_d = {24'b0, y0_q};
            REG_W:      rdata_d = {23'b0, w_q};
            REG_H:      rdata_d = {23'b0, h_q};
            REG_COLOR:  rdata_d = {{(32-COLOR_W){1'b0}}, color_q};
            REG_PIXCNT: rdata_d = {15'b0, pixcnt_q};
            default:    rdata_d = '0;
        endcase
    end

    // State register; reset returns everything to zero / IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            x0_q          <= '0;
            y0_q          <= '0;
            w_q           <= '0;
            h_q           <= '0;
            color_q       <= '0;
            lx0_q         <= '0;
            ly0_q         <= '0;
            lw_q          <= '0;
            lh_q          <= '0;
            lcolor_q      <= '0;
            xe_q          <= '0;
            ye_q          <= '0;
            cx_q          <= '0;
            cy_q          <= '0;
            pixcnt_q      <= '0;
            done_sticky_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            x0_q          <= x0_d;
            y0_q          <= y0_d;
            w_q           <= w_d;
            h_q           <= h_d;
            color_q       <= color_d;
            lx0_q         <= lx0_d;
            ly0_q         <= ly0_d;
            lw_q          <= lw_d;
            lh_q          <= lh_d;
            lcolor_q      <= lcolor_d;
            xe_q          <= xe_d;
            ye_q          <= ye_d;
            cx_q          <= cx_d;
            cy_q          <= cy_d;
            pixcnt_q      <= pixcnt_d;
            done_sticky_q <= done_sticky_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            rdata_q       <= rdata_d;
        end
    end

endmodule

// File: tb/tb_vmem_rect_fill.sv
// Directed bench for vmem_rect_fill: basic fill, clipping, empty fill,
// CPU contention, start-while-busy with reprogramming, and mid-fill reset.
module tb_vmem_rect_fill;
    import vmem_rect_fill_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vmem_rect_fill_if #(.COLOR_W(3)) bus ();

    vmem_rect_fill #(.SCREEN_W(240), .SCREEN_H(240), .COLOR_W(3)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_wr_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    logic [15:0] wr_addr[$];
    logic [2:0]  wr_data[$];
    int          wr_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Log every vmem write and every done pulse mid-cycle
    always @(negedge clk) begin
        if (bus.vmem_we_o === 1'b1) begin
            wr_addr.push_back(bus.vmem_addr_o);
            wr_data.push_back(bus.vmem_wdata_o);
            wr_cyc.push_back(cyc);
        end
        if (bus.done_o === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    task automatic reg_wr(input logic [2:0] idx, input logic [31:0] d);
        @(posedge clk); #1;
        bus.reg_we_i    = 1'b1;
        bus.reg_addr_i  = {idx, 2'b00};
        bus.reg_wdata_i = d;
        last_wr_cyc     = cyc;
        @(posedge clk); #1;
        bus.reg_we_i    = 1'b0;
        bus.reg_wdata_i = '0;
    endtask

    task automatic reg_rd(input logic [2:0] idx, output logic [31:0] d);
        @(posedge clk); #1;
        bus.reg_addr_i = {idx, 2'b00};
        @(posedge clk); #1;
        d = bus.reg_rdata_o;
    endtask

    task automatic prog(input int x0, input int y0, input int w, input int h, input int col);
        reg_wr(REG_X0, x0);
        reg_wr(REG_Y0, y0);
        reg_wr(REG_W, w);
        reg_wr(REG_H, h);
        reg_wr(REG_COLOR, col);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int c0;
        int i;
        c0 = done_cnt;
        i  = 0;
        while (done_cnt == c0 && i < budget) begin
            @(posedge clk);
            i++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt != c0), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic [15:0] e_addr[6];
        logic [2:0]  e_data[6];
        int          e_off[6];
        int          t;
        int          d0;
        int          bad;
        int          k;

        bus.reg_we_i         = 1'b0;
        bus.reg_addr_i       = '0;
        bus.reg_wdata_i      = '0;
        bus.cpu_vmem_we_i    = 1'b0;
        bus.cpu_vmem_addr_i  = '0;
        bus.cpu_vmem_wdata_i = '0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_we", 32'(bus.vmem_we_o), 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_done", 32'(bus.done_o), 32'd0);
        chk("rst_rdata", bus.reg_rdata_o, 32'd0);
        for (int i = 0; i < 8; i++) begin
            reg_rd(3'(i), rd);
            chk($sformatf("rst_reg%0d", i), rd, 32'd0);
        end

        // Basic 3x2 fill at (10,20), colour 5
        prog(10, 20, 3, 2, 5);
        clear_log();
        reg_wr(REG_CTRL, 32'd1);
        t = last_wr_cyc;
        wait_done("t1", 100);
        chk("t1_nwr", 32'(wr_addr.size()), 32'd6);
        e_addr = '{16'h140A, 16'h140B, 16'h140C, 16'h150A, 16'h150B, 16'h150C};
        for (int i = 0; i < 6; i++) begin
            if (i < wr_addr.size()) begin
                chk($sformatf("t1_addr%0d", i), 32'(wr_addr[i]), 32'(e_addr[i]));
                chk($sformatf("t1_data%0d", i), 32'(wr_data[i]), 32'd5);
                chk($sformatf("t1_cyc%0d", i), 32'(wr_cyc[i] - t), 32'(i + 2));
            end
        end
        chk("t1_done_lat", 32'(done_cyc - t), 32'd8);
        reg_rd(REG_PIXCNT, rd);
        chk("t1_pixcnt", rd, 32'd6);
        reg_rd(REG_CTRL, rd);
        chk("t1_ctrl", rd, 32'h2);

        // Clipping at the bottom-right corner
        prog(238, 239, 10, 10, 4);
        clear_log();
        reg_wr(REG_CTRL, 32'd1);
        t = last_wr_cyc;
        wait_done("t2", 100);
        chk("t2_nwr", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() >= 2) begin
            chk("t2_addr0", 32'(wr_addr[0]), 32'hEFEE);
            chk("t2_addr1", 32'(wr_addr[1]), 32'hEFEF);
            chk("t2_data1", 32'(wr_data[1]), 32'd4);
        end
        chk("t2_done_lat", 32'(done_cyc - t), 32'd4);
        reg_rd(REG_PIXCNT, rd);
        chk("t2_pixcnt", rd, 32'd2);

        // Zero width
        prog(5, 5, 0, 5, 1);
        clear_log();
        reg_wr(REG_CTRL, 32'd1);
        t = last_wr_cyc;
        wait_done("t3", 50);
        chk("t3_nwr", 32'(wr_addr.size()), 32'd0);
        chk("t3_done_lat", 32'(done_cyc - t), 32'd2);
        reg_rd(REG_CTRL, rd);
        chk("t3_ctrl", rd, 32'h2);
        reg_rd(REG_PIXCNT, rd);
        chk("t3_pixcnt", rd, 32'd0);

        // CPU writes in the 2nd and 3rd fill cycles of a 4x1 fill
        prog(0, 0, 4, 1, 1);
        clear_log();
        @(posedge clk); #1;
        bus.reg_we_i    = 1'b1;
        bus.reg_addr_i  = {REG_CTRL, 2'b00};
        bus.reg_wdata_i = 32'd1;
        t = cyc;
        @(posedge clk); #1;
        bus.reg_we_i    = 1'b0;
        bus.reg_wdata_i = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.cpu_vmem_we_i    = 1'b1;
        bus.cpu_vmem_addr_i  = 16'h0505;
        bus.cpu_vmem_wdata_i = 3'd7;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.cpu_vmem_we_i    = 1'b0;
        bus.cpu_vmem_addr_i  = '0;
        bus.cpu_vmem_wdata_i = '0;
        wait_done("t4", 50);
        e_addr = '{16'h0000, 16'h0505, 16'h0505, 16'h0001, 16'h0002, 16'h0003};
        e_data = '{3'd1, 3'd7, 3'd7, 3'd1, 3'd1, 3'd1};
        e_off  = '{2, 3, 4, 5, 6, 7};
        chk("t4_nwr", 32'(wr_addr.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < wr_addr.size()) begin
                chk($sformatf("t4_addr%0d", i), 32'(wr_addr[i]), 32'(e_addr[i]));
                chk($sformatf("t4_data%0d", i), 32'(wr_data[i]), 32'(e_data[i]));
                chk($sformatf("t4_cyc%0d", i), 32'(wr_cyc[i] - t), 32'(e_off[i]));
            end
        end
        chk("t4_done_lat", 32'(done_cyc - t), 32'd8);
        reg_rd(REG_PIXCNT, rd);
        chk("t4_pixcnt", rd, 32'd4);

        // Full-screen fill; reprogram colour and re-issue start while busy
        prog(0, 0, 240, 240, 3);
        clear_log();
        d0 = done_cnt;
        reg_wr(REG_CTRL, 32'd1);
        t = last_wr_cyc;
        repeat (50) @(posedge clk);
        #1;
        chk("t5_busy", 32'(bus.busy_o), 32'd1);
        reg_wr(REG_COLOR, 32'd2);
        reg_wr(REG_CTRL, 32'd1);
        wait_done("t5", 60000);
        repeat (10) @(posedge clk);
        #1;
        chk("t5_nwr", 32'(wr_addr.size()), 32'd57600);
        bad = 0;
        foreach (wr_data[i]) if (wr_data[i] !== 3'd3) bad++;
        chk("t5_bad_colour", 32'(bad), 32'd0);
        k = wr_addr.size();
        if (k > 0) chk("t5_last_addr", 32'(wr_addr[k-1]), 32'hEFEF);
        chk("t5_done_lat", 32'(done_cyc - t), 32'd57602);
        chk("t5_done_pulses", 32'(done_cnt - d0), 32'd1);
        reg_rd(REG_PIXCNT, rd);
        chk("t5_pixcnt", rd, 32'd57600);
        reg_rd(REG_COLOR, rd);
        chk("t5_colour_reg", rd, 32'd2);

        // Second start picks up the new colour
        reg_wr(REG_W, 32'd2);
        reg_wr(REG_H, 32'd1);
        clear_log();
        reg_wr(REG_CTRL, 32'd1);
        wait_done("t5b", 50);
        chk("t5b_nwr", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() >= 2) begin
            chk("t5b_data0", 32'(wr_data[0]), 32'd2);
            chk("t5b_data1", 32'(wr_data[1]), 32'd2);
            chk("t5b_addr1", 32'(wr_addr[1]), 32'h0001);
        end

        // Reset after 100 pixels of a 50x50 fill
        prog(0, 0, 50, 50, 6);
        clear_log();
        d0 = done_cnt;
        reg_wr(REG_CTRL, 32'd1);
        k = 0;
        while (wr_addr.size() < 100 && k < 1000) begin
            @(negedge clk); #1;
            k++;
        end
        chk("t6_reached100", 32'(wr_addr.size()), 32'd100);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_busy", 32'(bus.busy_o), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("t6_nwr", 32'(wr_addr.size()), 32'd100);
        chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
        chk("t6_busy_late", 32'(bus.busy_o), 32'd0);
        for (int i = 0; i < 8; i++) begin
            reg_rd(3'(i), rd);
            chk($sformatf("t6_reg%0d", i), rd, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
